// File: rtl/sfft_frame_reader.sv
`timescale 1ns/1ps
`default_nettype none
// sfft_frame_reader: locks the FFT output buffer, fetches timestamp and all spectrum
// words byte-by-byte, streams them out little-endian, then releases the lock. rev 1.0
module sfft_frame_reader #(
   parameter int NFFT         = 512,
   parameter int READ_LATENCY = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic                      frame_error,
   output logic [31:0]               timestamp,
   output logic [31:0]               out_data,
   output logic [$clog2(NFFT)-2:0]   out_index,
   output logic                      out_last,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [15:0]               avm_address,
   output logic                      avm_chipselect,
   output logic                      avm_write,
   output logic [7:0]                avm_writedata,
   input  logic [7:0]                avm_readdata
);

   localparam int IDX_W = $clog2(NFFT) - 1;
   localparam int LAT_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);

   localparam logic [LAT_W-1:0] c_LAT        = LAT_W'(READ_LATENCY);
   localparam logic [IDX_W-1:0] c_LAST_K     = IDX_W'(NFFT / 2 - 1);
   localparam logic [15:0]      c_TIME_ADDR  = 16'(2 * NFFT);
   localparam logic [15:0]      c_VALID_ADDR = 16'(2 * NFFT + 4);

   localparam logic [2:0] c_IDLE     = 3'd0;
   localparam logic [2:0] c_LOCK     = 3'd1;
   localparam logic [2:0] c_CHKVALID = 3'd2;
   localparam logic [2:0] c_TIME     = 3'd3;
   localparam logic [2:0] c_BINS     = 3'd4;
   localparam logic [2:0] c_EMIT     = 3'd5;
   localparam logic [2:0] c_RELEASE  = 3'd6;
   localparam logic [2:0] c_DONE     = 3'd7;

   logic [2:0]       r_state;
   logic [IDX_W-1:0] r_k;
   logic [1:0]       r_byte;
   logic [LAT_W-1:0] r_wait;
   logic             r_err;
   logic [23:0]      r_shadow;
   logic [31:0]      r_asm;
   logic [31:0]      r_timestamp;
   logic             w_sample;

   // The byte address is held for READ_LATENCY+1 cycles; data is taken on the last one.
   assign w_sample = (r_wait == c_LAT);

   always_comb begin
      avm_address    = 16'd0;
      avm_chipselect = 1'b0;
      avm_write      = 1'b0;
      avm_writedata  = 8'h00;
      case (r_state)
         c_LOCK: begin
            avm_chipselect = 1'b1;
            avm_write      = 1'b1;
            avm_writedata  = 8'h01;
         end
         c_RELEASE: begin
            avm_chipselect = 1'b1;
            avm_write      = 1'b1;
         end
         c_CHKVALID: avm_address = c_VALID_ADDR;
         c_TIME:     avm_address = c_TIME_ADDR + 16'(r_byte);
         c_BINS:     avm_address = 16'({r_k, r_byte});
         default:    ;
      endcase
   end

   assign busy        = (r_state != c_IDLE);
   assign done        = (r_state == c_DONE);
   assign frame_error = done & r_err;
   assign out_valid   = (r_state == c_EMIT);
   assign out_last    = out_valid & (r_k == c_LAST_K);
   assign out_data    = r_asm;
   assign out_index   = r_k;
   assign timestamp   = r_timestamp;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= c_IDLE;
         r_k         <= '0;
         r_byte      <= '0;
         r_wait      <= '0;
         r_err       <= 1'b0;
         r_shadow    <= '0;
         r_asm       <= '0;
         r_timestamp <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (start) begin
                  r_state <= c_LOCK;
                  r_err   <= 1'b0;
                  r_k     <= '0;
                  r_byte  <= '0;
                  r_wait  <= '0;
               end
            end
            c_LOCK: r_state <= c_CHKVALID;
            c_CHKVALID: begin
               if (w_sample) begin
                  r_wait <= '0;
                  if (avm_readdata[0]) begin
                     r_state <= c_TIME;
                  end else begin
                     r_err   <= 1'b1;
                     r_state <= c_RELEASE;
                  end
               end else begin
                  r_wait <= r_wait + LAT_W'(1);
               end
            end
            c_TIME: begin
               if (w_sample) begin
                  r_wait <= '0;
                  r_byte <= r_byte + 2'd1;
                  // Shadow keeps the low three bytes so the visible timestamp changes only once.
                  if (r_byte == 2'd3) begin
                     r_timestamp <= {avm_readdata, r_shadow};
                     r_state     <= c_BINS;
                  end else begin
                     r_shadow <= {avm_readdata, r_shadow[23:8]};
                  end
               end else begin
                  r_wait <= r_wait + LAT_W'(1);
               end
            end
            c_BINS: begin
               if (w_sample) begin
                  r_wait <= '0;
                  r_byte <= r_byte + 2'd1;
                  r_asm  <= {avm_readdata, r_asm[31:8]};
                  if (r_byte == 2'd3) begin
                     r_state <= c_EMIT;
                  end
               end else begin
                  r_wait <= r_wait + LAT_W'(1);
               end
            end
            c_EMIT: begin
               if (out_ready) begin
                  if (r_k == c_LAST_K) begin
                     r_state <= c_RELEASE;
                  end else begin
                     r_k     <= r_k + IDX_W'(1);
                     r_state <= c_BINS;
                  end
               end
            end
            c_RELEASE: r_state <= c_DONE;
            c_DONE:    r_state <= c_IDLE;
            default:   r_state <= c_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
